// File: rtl/program_sequencer.sv
// Instruction-supply stage: assembles a byte-streamed program into a word memory, then issues
// the stored words in order over a valid/ready port, once or looping.
module program_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [7:0]      load_byte,
  output logic            load_ready,
  input  logic            load_done,
  input  logic            start,
  input  logic            loop,
  input  logic            halt,
  output logic            instr_valid,
  output logic [31:0]     instr,
  input  logic            instr_ready,
  output logic [AW-1:0]   pc,
  output logic [AW:0]     prog_len,
  output logic [15:0]     issue_cnt,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [AW:0] LenMax = (AW+1)'(DEPTH);

  state_e      state;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic [31:0] mem [DEPTH];

  logic       accept;
  logic       word_wr;
  logic       last;
  logic       xfer;
  logic [1:0] cnt_next;

  assign busy        = (state != StIdle);
  assign load_ready  = (state == StLoad) && (prog_len < LenMax);
  assign instr_valid = (state == StRun);
  assign instr       = instr_valid ? mem[pc] : '0;

  // A restart in the same cycle discards any byte offered alongside it.
  assign accept   = load_ready && load_valid && !load_start;
  assign word_wr  = accept && (byte_cnt == 2'd3);
  assign cnt_next = accept ? byte_cnt + 2'd1 : byte_cnt;
  assign last     = ({1'b0, pc} == prog_len - (AW+1)'(1));
  assign xfer     = instr_valid && instr_ready;

  // Program memory is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (word_wr) begin
      mem[prog_len[AW-1:0]] <= {asm_q, load_byte};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      pc        <= '0;
      prog_len  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      issue_cnt <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (load_start) begin
            state    <= StLoad;
            prog_len <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
          end else if (start && (prog_len != '0)) begin
            state     <= StRun;
            pc        <= '0;
            issue_cnt <= '0;
          end
        end
        StLoad: begin
          if (load_start) begin
            prog_len <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
          end else begin
            if (load_valid && !load_ready) err <= 1'b1;
            if (accept) begin
              asm_q    <= {asm_q[15:0], load_byte};
              byte_cnt <= cnt_next;
            end
            if (word_wr) prog_len <= prog_len + (AW+1)'(1);
            // The same-cycle byte has already been counted into cnt_next.
            if (load_done) begin
              state <= StIdle;
              if (cnt_next != 2'd0) begin
                err      <= 1'b1;
                byte_cnt <= '0;
              end
            end
          end
        end
        StRun: begin
          if (xfer) begin
            issue_cnt <= issue_cnt + 16'd1;
            if (last) begin
              pc <= '0;
              if (!loop) state <= StIdle;
            end else begin
              pc <= pc + AW'(1);
            end
          end
          if (halt) begin
            state <= StIdle;
            pc    <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
